// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - op and state encodings plus sizing constants for the HI/LO mult/div sequencer
package xalu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MUL   = 3'd6,
    OP_RSVD  = 3'd7
  } xalu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } xalu_state_e;

  localparam int DIV_CYCLES     = 33;
  localparam int MUL_CYCLES_MAX = 8;
  localparam int MUL_CNT_W      = $clog2(MUL_CYCLES_MAX + 1);

endpackage

// File: rtl/xalu_div_core.sv
// rtl/xalu_div_core.sv - iterative restoring divider: 32 magnitude steps plus one sign-fix cycle
// XALU_DIV_FASTPATH_EN: finish in one cycle when the divisor is zero or |dividend| < |divisor|.
module xalu_div_core
  import xalu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [31:0] a_mag, b_mag;
  logic [32:0] trial;
  logic        fast;

  always_comb begin
    a_mag = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    b_mag = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
`ifdef XALU_DIV_FASTPATH_EN
    fast = (divisor_i == 32'd0) || (a_mag < b_mag);
`else
    fast = 1'b0;
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    a_d    = a_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    ovf_d  = ovf_q;
    trial  = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (load_i) begin
      // The quotient register starts out holding the dividend and is shifted out MSB-first.
      cnt_d  = fast ? 6'd1 : 6'(DIV_CYCLES);
      rem_d  = fast ? a_mag : 32'd0;
      quo_d  = fast ? 32'd0 : a_mag;
      dvs_d  = b_mag;
      a_d    = dividend_i;
      qneg_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
      rneg_d = signed_i && dividend_i[31];
      dz_d   = (divisor_i == 32'd0);
      ovf_d  = signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    end else if (cnt_q > 6'd1) begin
      cnt_d = cnt_q - 6'd1;
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
    end else if (cnt_q == 6'd1) begin
      cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= 6'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      a_q    <= 32'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      a_q    <= a_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      ovf_q  <= ovf_d;
    end
  end

  // Sign fix happens combinationally during the final cycle; the owner registers it.
  assign done_o      = (cnt_q == 6'd1);
  assign quotient_o  = dz_q ? 32'hFFFF_FFFF : ovf_q ? 32'h8000_0000 :
                       qneg_q ? -quo_q : quo_q;
  assign remainder_o = dz_q ? a_q : ovf_q ? 32'd0 : rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/xalu_ctrl.sv
// rtl/xalu_ctrl.sv - mult/div sequencer owning HI/LO; busy gates later mult-family issues
// XALU_DIV_FASTPATH_EN (in xalu_div_core) shortens trivial divides to a single busy cycle.
module xalu_ctrl
  import xalu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mul_result_o,
  output logic        mul_valid_o
);

  localparam logic [MUL_CNT_W-1:0] MUL_L = MUL_CNT_W'(MUL_CYCLES);

  xalu_state_e          state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]          prod_q, prod_d;
  logic                 is_mul_q, is_mul_d;
  logic [31:0]          hi_q, hi_d, lo_q, lo_d, mulr_q, mulr_d;
  logic                 mulv_q, mulv_d, busy_q, busy_d;

  xalu_op_e             op_e;
  logic signed [63:0]   a_sx, b_sx;
  logic [63:0]          prod_s, prod_u;
  logic                 div_load, div_signed, div_done;
  logic [31:0]          div_quo, div_rem;

  assign op_e   = xalu_op_e'(op_i);
  assign a_sx   = {{32{src_a_i[31]}}, src_a_i};
  assign b_sx   = {{32{src_b_i[31]}}, src_b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

  xalu_div_core u_div (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (div_load),
    .signed_i    (div_signed),
    .dividend_i  (src_a_i),
    .divisor_i   (src_b_i),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    is_mul_d   = is_mul_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mulr_d     = mulr_q;
    mulv_d     = 1'b0;
    div_load   = 1'b0;
    div_signed = (op_e == OP_DIV);
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          case (op_e)
            OP_MULT, OP_MULTU, OP_MUL: begin
              // Product is taken at issue; the counter only models the pipeline latency.
              state_d  = ST_MUL;
              cnt_d    = MUL_L;
              prod_d   = (op_e == OP_MULTU) ? prod_u : prod_s;
              is_mul_d = (op_e == OP_MUL);
            end
            OP_DIV, OP_DIVU: begin
              state_d  = ST_DIV;
              div_load = 1'b1;
            end
            OP_MTHI: hi_d = src_a_i;
            OP_MTLO: lo_d = src_a_i;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == MUL_CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (is_mul_q) begin
            mulr_d = prod_q[31:0];
            mulv_d = 1'b1;
          end else begin
            hi_d = prod_q[63:32];
            lo_d = prod_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - MUL_CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_IDLE;
          hi_d    = div_rem;
          lo_d    = div_quo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= 64'd0;
      is_mul_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      mulr_q   <= 32'd0;
      mulv_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      is_mul_q <= is_mul_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mulr_q   <= mulr_d;
      mulv_q   <= mulv_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign mul_result_o = mulr_q;
  assign mul_valid_o  = mulv_q;

endmodule

// File: doc/xalu_ctrl.md
# xalu_ctrl

Multi-cycle multiply/divide sequencer owning the HI/LO architectural registers. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO/MUL issue per operation from the E stage, runs it over a fixed cycle count, and reports `busy` to the hazard unit, which stalls later mult-family instructions. Sits beside the main ALU in the execute stage; HI/LO outputs feed MFHI/MFLO.

## Interface
- `MUL_CYCLES`, default 3: multiply latency L in cycles, legal range 1..8.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MUL; 7 reserved, ignored.
- `src_a`  in  32  rs value (dividend / multiplicand / MTHI-MTLO data).
- `src_b`  in  32  rt value.
- `flush`  in  1  exception flush; cancels a `start` in the same cycle.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`, `lo`  out  32  architectural HI/LO.
- `mul_result`  out  32  low word of the last MUL; held until the next MUL completes.
- `mul_valid`  out  1  one-cycle pulse when `mul_result` updates.

## Operation
- FSM states: IDLE, MUL, DIV. Reset and idle state: IDLE. Reset values: `busy`=0, `hi`=`lo`=0, `mul_result`=0, `mul_valid`=0, counter=0.
- IDLE with `start`=1, `flush`=0:
  - ops 0/1/6 go to MUL; counter loads L.
  - ops 2/3 go to DIV; the divider core is loaded.
  - ops 4/5 write `hi`/`lo` at that edge; state stays IDLE; `busy` never rises.
- `start` with `flush`=1 is dropped: no state change, no register write.
- `start` outside IDLE is ignored. The hazard unit prevents it; the bench flags it as an error.
- MUL state: 64-bit product (signed for ops 0/6, unsigned for op 1) is captured at issue and carried through a counter-timed hold. On the last count:
  - MULT/MULTU write {`hi`,`lo`}.
  - MUL writes `mul_result` and pulses `mul_valid`. HI/LO are unchanged.
- DIV state: 32-iteration restoring divide on magnitudes, plus one sign-fix cycle, 33 cycles total.
  - Quotient is negative when the operand signs differ (signed only). Remainder takes the sign of the dividend.
  - `lo`=quotient, `hi`=remainder.
- Divide by zero, any sign: `hi`=`src_a`, `lo`=32'hFFFF_FFFF.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF: `lo`=32'h8000_0000, `hi`=0.
- `flush` has no effect on an operation already in flight; it belongs to an older, committed instruction.
- `reset` asserted mid-operation aborts to IDLE with all outputs at their reset values.

## Timing
- Issue edge is edge 0. `busy`=1 during cycles 1..N, where N=L for MUL-state ops and N=33 for DIV.
- Results are written at the edge ending cycle N. They are visible in cycle N+1 with `busy`=0.
- `mul_valid`=1 in cycle N+1 only.
- A new `start` is accepted in cycle N+1, so back-to-back throughput is one operation per N+1 cycles.
- MTHI/MTLO: result visible in cycle 1, zero busy cycles.

## Configuration
- `XALU_DIV_FASTPATH_EN` defined:
  - Fast path applies when the divisor is zero or |`src_a`| < |`src_b`| (unsigned compare for DIVU).
  - On the fast path, DIV finishes with N=1: `busy` for cycle 1 only, results visible in cycle 2.
  - Fast-path results: quotient 0 and remainder `src_a`; divide by zero uses the values above.
- Undefined: every divide takes N=33. Result values are identical in both builds.

## Structure
- `xalu_pkg`: op encoding enum, FSM state enum, `DIV_CYCLES`=33, `MUL_CYCLES_MAX`=8.
- Sub-module `xalu_div_core`: iterative restoring divider.
  - Inputs: `load`, `signed_op`, operands.
  - Outputs: `done` pulse, quotient, remainder.
  - Contains the sign fix and the divide-by-zero and overflow handling.
- The multiply path, counter and HI/LO registers live in `xalu_ctrl`.

## Test plan
- MULT -3 × 5, L=3 → `busy` in cycles 1–3; cycle 4: `hi`=FFFF_FFFF, `lo`=FFFF_FFF1.
- DIVU 100 / 7 → `busy` 33 cycles, then `lo`=14, `hi`=2. DIV -7 / 2 → `lo`=FFFF_FFFD, `hi`=FFFF_FFFF.
- DIV by 0 with `src_a`=1234 → `hi`=1234, `lo`=FFFF_FFFF. Length is 33 cycles, or 1 with `XALU_DIV_FASTPATH_EN`.
- MTHI 0xDEAD_BEEF with `flush`=1 → `hi` unchanged. Same without flush → `hi`=DEAD_BEEF next cycle, `busy` stays 0.
- MUL 0x1_0000 × 0x1_0000 → `mul_valid` pulse in cycle L+1 with `mul_result`=0; `hi`/`lo` unchanged.
- Start DIVU, assert `reset` in cycle 10 → `busy`=0, `hi`=`lo`=0 immediately; next MULTU 2×3 gives `lo`=6.
